// File: rtl/noc_sa_pkg.sv
// Shared types and direction encodings for the switch allocator.
package noc_sa_pkg;

  typedef enum logic {
    SA_IDLE   = 1'b0,
    SA_LOCKED = 1'b1
  } sa_state_t;

  localparam int unsigned DIR_NORTH = 0;
  localparam int unsigned DIR_EAST  = 1;
  localparam int unsigned DIR_SOUTH = 2;
  localparam int unsigned DIR_WEST  = 3;
  localparam int unsigned DIR_LOCAL = 4;

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: first requester scanning last+1, last+2, ... modulo N_PORTS.
module rr_arbiter_n #(
  parameter int unsigned N_PORTS = 5,
  parameter int unsigned PTR_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PTR_W-1:0]   last,
  output logic [N_PORTS-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  int unsigned      cand;
  logic [PTR_W-1:0] cidx;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int unsigned k = 1; k <= N_PORTS; k++) begin
      // explicit wrap so non-power-of-2 port counts scan correctly
      cand = last + k;
      if (cand >= N_PORTS) cand = cand - N_PORTS;
      cidx = cand[PTR_W-1:0];
      if (!any && req[cidx]) begin
        any         = 1'b1;
        grant[cidx] = 1'b1;
        idx         = cidx;
      end
    end
  end

endmodule

// File: rtl/switch_allocator_rr.sv
// Per-output round-robin switch allocator with wormhole lock and credit gating.
// Optional per-output grant counters when SA_PERF_CNT_EN is defined.
module switch_allocator_rr
  import noc_sa_pkg::*;
#(
  parameter int unsigned N_PORTS = 5,
  parameter int unsigned PTR_W   = $clog2(N_PORTS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [0:N_PORTS-1]            i_req,
  input  logic [0:N_PORTS-1][PTR_W-1:0] i_req_dir,
  input  logic [0:N_PORTS-1]            i_tail,
  input  logic [0:N_PORTS-1]            i_credit_avail,
  output logic [0:N_PORTS-1]            o_in_grant,
  output logic [0:N_PORTS-1]            o_out_valid,
  output logic [0:N_PORTS-1][PTR_W-1:0] o_out_sel
`ifdef SA_PERF_CNT_EN
  ,
  output logic [0:N_PORTS-1][31:0]      o_grant_cnt
`endif
);

  sa_state_t        state_q [N_PORTS];
  sa_state_t        state_d [N_PORTS];
  logic [PTR_W-1:0] owner_q [N_PORTS];
  logic [PTR_W-1:0] owner_d [N_PORTS];
  logic [PTR_W-1:0] rr_q    [N_PORTS];
  logic [PTR_W-1:0] rr_d    [N_PORTS];

  logic [N_PORTS-1:0] elig      [N_PORTS];
  logic [N_PORTS-1:0] arb_grant [N_PORTS];
  logic [PTR_W-1:0]   arb_idx   [N_PORTS];
  logic               arb_any   [N_PORTS];

  logic [0:N_PORTS-1] in_grant;
  logic [0:N_PORTS-1] out_valid;
  logic [PTR_W-1:0]   out_sel [N_PORTS];

  always_comb begin
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      elig[o] = '0;
      for (int unsigned i = 0; i < N_PORTS; i++)
        elig[o][i] = i_req[i] && (i_req_dir[i] == PTR_W'(o));
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_arb
    rr_arbiter_n #(
      .N_PORTS(N_PORTS),
      .PTR_W  (PTR_W)
    ) u_arb (
      .req  (elig[g]),
      .last (rr_q[g]),
      .grant(arb_grant[g]),
      .idx  (arb_idx[g]),
      .any  (arb_any[g])
    );
  end

  always_comb begin
    in_grant  = '0;
    out_valid = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      out_sel[o] = '0;
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      case (state_q[o])
        SA_IDLE: begin
          if (i_credit_avail[o] && arb_any[o]) begin
            out_valid[o] = 1'b1;
            out_sel[o]   = arb_idx[o];
            for (int unsigned i = 0; i < N_PORTS; i++)
              if (arb_grant[o][i]) in_grant[i] = 1'b1;
            if (i_tail[arb_idx[o]]) begin
              rr_d[o] = arb_idx[o];
            end else begin
              state_d[o] = SA_LOCKED;
              owner_d[o] = arb_idx[o];
            end
          end
        end
        SA_LOCKED: begin
          if (i_req[owner_q[o]] && (i_req_dir[owner_q[o]] == PTR_W'(o)) &&
              i_credit_avail[o]) begin
            out_valid[o]         = 1'b1;
            out_sel[o]           = owner_q[o];
            in_grant[owner_q[o]] = 1'b1;
            if (i_tail[owner_q[o]]) begin
              state_d[o] = SA_IDLE;
              rr_d[o]    = owner_q[o];
            end
          end
        end
        default: state_d[o] = SA_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned o = 0; o < N_PORTS; o++) begin
        state_q[o] <= SA_IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= PTR_W'(N_PORTS - 1);
      end
    end else begin
      for (int unsigned o = 0; o < N_PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
      end
    end
  end

  assign o_in_grant  = reset_n ? in_grant  : '0;
  assign o_out_valid = reset_n ? out_valid : '0;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_out
    assign o_out_sel[g] = reset_n ? out_sel[g] : '0;

    a_owner_dir_stable : assert property (
      @(posedge clk) disable iff (!reset_n)
      (state_q[g] == SA_LOCKED && i_req[owner_q[g]]) |->
        (i_req_dir[owner_q[g]] == PTR_W'(g))
    );
  end

`ifdef SA_PERF_CNT_EN
  logic [31:0] grant_cnt [N_PORTS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned o = 0; o < N_PORTS; o++) grant_cnt[o] <= '0;
    end else begin
      for (int unsigned o = 0; o < N_PORTS; o++)
        if (out_valid[o] && (grant_cnt[o] != '1))
          grant_cnt[o] <= grant_cnt[o] + 32'd1;
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_cnt
    assign o_grant_cnt[g] = grant_cnt[g];
  end
`endif

endmodule

// File: tb/tb_switch_allocator_rr.sv
// Directed self-checking bench for switch_allocator_rr.
module tb_switch_allocator_rr;
  import noc_sa_pkg::*;

  localparam int unsigned N  = 5;
  localparam int unsigned PW = 3;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [0:N-1]        req, tail, credit;
  logic [0:N-1][PW-1:0] dir;
  logic [0:N-1]        in_grant, out_valid;
  logic [0:N-1][PW-1:0] out_sel;
`ifdef SA_PERF_CNT_EN
  logic [0:N-1][31:0]  grant_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  switch_allocator_rr #(
    .N_PORTS(N),
    .PTR_W  (PW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_req         (req),
    .i_req_dir     (dir),
    .i_tail        (tail),
    .i_credit_avail(credit),
    .o_in_grant    (in_grant),
    .o_out_valid   (out_valid),
    .o_out_sel     (out_sel)
`ifdef SA_PERF_CNT_EN
    ,
    .o_grant_cnt   (grant_cnt)
`endif
  );

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    dir     = '0;
    tail    = '0;
    credit  = '1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = '1;
    tail    = '1;
    credit  = '1;
    for (int i = 0; i < N; i++) dir[i] = PW'(DIR_EAST);
    #3;
    checks++; if (in_grant !== '0) begin errors++; $display("FAIL reset_grant: got %b want 00000", in_grant); end
    checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_valid: got %b want 00000", out_valid); end
    checks++; if (out_sel !== '0) begin errors++; $display("FAIL reset_sel: got %h want 0", out_sel); end
    next_cycle();
    checks++; if (in_grant !== '0) begin errors++; $display("FAIL reset_grant_edge: got %b want 00000", in_grant); end
    checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_valid_edge: got %b want 00000", out_valid); end
    reset_n = 1'b1;
    req = '0;
  endtask

  task automatic test_rr_fairness();
    logic [0:N-1] exp_g;
    int e;
    do_reset();
    req  = '1;
    tail = '1;
    for (int i = 0; i < N; i++) dir[i] = PW'(DIR_EAST);
    for (int k = 0; k < 6; k++) begin
      e = k % N;
      exp_g = '0;
      exp_g[e] = 1'b1;
      @(negedge clk);
      checks++; if (in_grant !== exp_g) begin errors++; $display("FAIL rr_grant k=%0d: got %b want %b", k, in_grant, exp_g); end
      checks++; if (out_sel[1] !== PW'(e)) begin errors++; $display("FAIL rr_sel k=%0d: got %0d want %0d", k, out_sel[1], e); end
      checks++; if (out_valid !== 5'b01000) begin errors++; $display("FAIL rr_valid k=%0d: got %b want 01000", k, out_valid); end
      next_cycle();
    end
    req = '0;
  endtask

  task automatic test_wormhole();
    do_reset();
    req[2] = 1'b1;
    dir[2] = PW'(DIR_SOUTH);
    for (int f = 0; f < 4; f++) begin
      tail[2] = (f == 3);
      if (f >= 1) begin
        req[0]  = 1'b1;
        dir[0]  = PW'(DIR_SOUTH);
        tail[0] = 1'b1;
      end
      @(negedge clk);
      checks++; if (in_grant !== 5'b00100) begin errors++; $display("FAIL worm_grant f=%0d: got %b want 00100", f, in_grant); end
      checks++; if (out_sel[2] !== 3'd2) begin errors++; $display("FAIL worm_sel f=%0d: got %0d want 2", f, out_sel[2]); end
      next_cycle();
    end
    req[2] = 1'b0;
    @(negedge clk);
    checks++; if (in_grant !== 5'b10000) begin errors++; $display("FAIL worm_next_grant: got %b want 10000", in_grant); end
    checks++; if (out_sel[2] !== 3'd0) begin errors++; $display("FAIL worm_next_sel: got %0d want 0", out_sel[2]); end
    checks++; if (out_valid !== 5'b00100) begin errors++; $display("FAIL worm_next_valid: got %b want 00100", out_valid); end
    next_cycle();
    req = '0;
  endtask

  task automatic test_credit_stall();
    do_reset();
    req[1]  = 1'b1;
    dir[1]  = PW'(DIR_SOUTH);
    tail[1] = 1'b0;
    @(negedge clk);
    checks++; if (in_grant !== 5'b01000) begin errors++; $display("FAIL stall_head: got %b want 01000", in_grant); end
    next_cycle();
    credit[2] = 1'b0;
    req[4]    = 1'b1;
    dir[4]    = PW'(DIR_SOUTH);
    tail[4]   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (in_grant !== '0) begin errors++; $display("FAIL stall_grant c=%0d: got %b want 00000", c, in_grant); end
      checks++; if (out_valid !== '0) begin errors++; $display("FAIL stall_valid c=%0d: got %b want 00000", c, out_valid); end
      next_cycle();
    end
    credit[2] = 1'b1;
    for (int f = 0; f < 2; f++) begin
      tail[1] = (f == 1);
      @(negedge clk);
      checks++; if (in_grant !== 5'b01000) begin errors++; $display("FAIL stall_resume f=%0d: got %b want 01000", f, in_grant); end
      checks++; if (out_sel[2] !== 3'd1) begin errors++; $display("FAIL stall_resume_sel f=%0d: got %0d want 1", f, out_sel[2]); end
      next_cycle();
    end
    req[1] = 1'b0;
    @(negedge clk);
    checks++; if (in_grant !== 5'b00001) begin errors++; $display("FAIL stall_after: got %b want 00001", in_grant); end
    checks++; if (out_sel[2] !== 3'd4) begin errors++; $display("FAIL stall_after_sel: got %0d want 4", out_sel[2]); end
    next_cycle();
    req = '0;
  endtask

  task automatic test_parallel();
    do_reset();
    req    = 5'b11011;
    tail   = '1;
    dir[0] = PW'(DIR_NORTH);
    dir[1] = PW'(DIR_EAST);
    dir[3] = PW'(DIR_WEST);
    dir[4] = PW'(DIR_SOUTH);
    @(negedge clk);
    checks++; if (in_grant !== 5'b11011) begin errors++; $display("FAIL par_grant: got %b want 11011", in_grant); end
    checks++; if (out_valid !== 5'b11110) begin errors++; $display("FAIL par_valid: got %b want 11110", out_valid); end
    checks++; if (out_sel[0] !== 3'd0 || out_sel[1] !== 3'd1 || out_sel[2] !== 3'd4 ||
                  out_sel[3] !== 3'd3 || out_sel[4] !== 3'd0) begin
      errors++; $display("FAIL par_sel: got %0d %0d %0d %0d %0d want 0 1 4 3 0",
                         out_sel[0], out_sel[1], out_sel[2], out_sel[3], out_sel[4]);
    end
    next_cycle();
    req = '0;
  endtask

  task automatic test_no_credit_idle();
    do_reset();
    credit[1] = 1'b0;
    req[0]    = 1'b1;
    dir[0]    = PW'(DIR_EAST);
    tail[0]   = 1'b1;
    @(negedge clk);
    checks++; if (in_grant !== '0) begin errors++; $display("FAIL nocred_grant: got %b want 00000", in_grant); end
    checks++; if (out_sel[1] !== 3'd0) begin errors++; $display("FAIL nocred_sel: got %0d want 0", out_sel[1]); end
    next_cycle();
    credit[1] = 1'b1;
    @(negedge clk);
    checks++; if (in_grant !== 5'b10000) begin errors++; $display("FAIL nocred_restore: got %b want 10000", in_grant); end
    next_cycle();
    req = '0;
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    req[3]  = 1'b1;
    dir[3]  = PW'(DIR_WEST);
    tail[3] = 1'b0;
    @(negedge clk);
    checks++; if (in_grant !== 5'b00010) begin errors++; $display("FAIL rml_head: got %b want 00010", in_grant); end
    next_cycle();
    req[1]  = 1'b1;
    dir[1]  = PW'(DIR_WEST);
    tail[1] = 1'b1;
    @(negedge clk);
    checks++; if (in_grant !== 5'b00010) begin errors++; $display("FAIL rml_locked: got %b want 00010", in_grant); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (in_grant !== '0) begin errors++; $display("FAIL rml_rst_grant: got %b want 00000", in_grant); end
    checks++; if (out_valid !== '0) begin errors++; $display("FAIL rml_rst_valid: got %b want 00000", out_valid); end
    checks++; if (out_sel !== '0) begin errors++; $display("FAIL rml_rst_sel: got %h want 0", out_sel); end
    next_cycle();
    reset_n = 1'b1;
    req[3]  = 1'b0;
    @(negedge clk);
    checks++; if (in_grant !== 5'b01000) begin errors++; $display("FAIL rml_after_grant: got %b want 01000", in_grant); end
    checks++; if (out_sel[3] !== 3'd1) begin errors++; $display("FAIL rml_after_sel: got %0d want 1", out_sel[3]); end
    checks++; if (out_valid !== 5'b00010) begin errors++; $display("FAIL rml_after_valid: got %b want 00010", out_valid); end
    next_cycle();
    req = '0;
  endtask

`ifdef SA_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    req[0]  = 1'b1;
    dir[0]  = PW'(DIR_EAST);
    tail[0] = 1'b1;
    repeat (10) next_cycle();
    req = '0;
    @(negedge clk);
    checks++; if (grant_cnt[1] !== 32'd10) begin errors++; $display("FAIL cnt_e: got %0d want 10", grant_cnt[1]); end
    checks++; if (grant_cnt[0] !== 32'd0) begin errors++; $display("FAIL cnt_n: got %0d want 0", grant_cnt[0]); end
    dut.grant_cnt[1] = 32'hFFFF_FFFD;
    next_cycle();
    req[0] = 1'b1;
    repeat (4) next_cycle();
    req = '0;
    @(negedge clk);
    checks++; if (grant_cnt[1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cnt_sat: got %h want ffffffff", grant_cnt[1]); end
    next_cycle();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    req     = '0;
    dir     = '0;
    tail    = '0;
    credit  = '1;
    test_reset();
    test_rr_fairness();
    test_wormhole();
    test_credit_stall();
    test_parallel();
    test_no_credit_idle();
    test_reset_mid_lock();
`ifdef SA_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
